// File: rtl/ape_sequencer.sv
// Purpose: job sequencer for the APE array; bias load, gated accumulate, finish trigger, then row-major tile readout.
// Latency: start to done = 1 bias + accepted/stalled ACCUM cycles + 1 finish + OUT_H*OUT_W accepted reads + 1 done.
// Backpressure: mpe_valid=0 stalls ACCUM; rd_ready=0 holds the readout address with rd_valid kept high.
module ape_sequencer #(
    parameter int OUT_H       = 8,
    parameter int OUT_W       = 8,
    parameter int OUT_BIN_LEN = 32,
    parameter int IDX_W       = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic [IDX_W-1:0]           num_indices,
    input  logic [OUT_BIN_LEN-1:0]     bias_in,
    input  logic                       mpe_valid,
    input  logic                       rd_ready,
    output logic                       busy,
    output logic                       done,
    output logic                       ape_w_enable,
    output logic [OUT_BIN_LEN-1:0]     ape_bias,
    output logic                       ape_enable,
    output logic                       ape_finish,
    output logic                       ape_r_enable,
    output logic [$clog2(OUT_H)-1:0]   ape_sram_r,
    output logic [$clog2(OUT_W)-1:0]   ape_sram_c,
    output logic                       rd_valid
);

    localparam int RW = $clog2(OUT_H);
    localparam int CW = $clog2(OUT_W);
    localparam logic [RW-1:0] ROW_LAST = RW'(OUT_H - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(OUT_W - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_BIAS   = 3'd1,
        S_ACCUM  = 3'd2,
        S_FINISH = 3'd3,
        S_READ   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t                 state;
    state_t                 state_n;
    logic [IDX_W-1:0]       idx_cnt;
    logic [IDX_W-1:0]       num_lat;
    logic [OUT_BIN_LEN-1:0] bias_lat;
    logic [RW-1:0]          row;
    logic [CW-1:0]          col;
    logic                   idx_last;
    logic                   col_last;
    logic                   tile_last;

    // num_lat is nonzero whenever ACCUM is entered, so the subtraction never wraps in use.
    assign idx_last  = (idx_cnt == (num_lat - IDX_W'(1)));
    assign col_last  = (col == COL_LAST);
    assign tile_last = col_last && (row == ROW_LAST);

    assign ape_bias   = bias_lat;
    assign ape_sram_r = row;
    assign ape_sram_c = col;
    // Accumulate strobe follows mpe_valid with no register so stalls cost nothing.
    assign ape_enable = (state == S_ACCUM) && mpe_valid;

    // Next-state decode; start is only looked at in IDLE.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (start) state_n = S_BIAS;
            S_BIAS:   state_n = (num_lat != '0) ? S_ACCUM : S_FINISH;
            S_ACCUM:  if (mpe_valid && idx_last) state_n = S_FINISH;
            S_FINISH: state_n = S_READ;
            S_READ:   if (rd_ready && tile_last) state_n = S_DONE;
            S_DONE:   state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    // State register, datapath counters and registered strobes decoded from the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_IDLE;
            idx_cnt      <= '0;
            num_lat      <= '0;
            bias_lat     <= '0;
            row          <= '0;
            col          <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            ape_w_enable <= 1'b0;
            ape_finish   <= 1'b0;
            ape_r_enable <= 1'b0;
            rd_valid     <= 1'b0;
        end else begin
            state        <= state_n;
            busy         <= (state_n != S_IDLE);
            done         <= (state_n == S_DONE);
            ape_w_enable <= (state_n == S_BIAS);
            ape_finish   <= (state_n == S_FINISH);
            ape_r_enable <= (state_n == S_READ);
            rd_valid     <= (state_n == S_READ);

            case (state)
                S_IDLE: begin
                    if (start) begin
                        num_lat  <= num_indices;
                        bias_lat <= bias_in;
                        idx_cnt  <= '0;
                        row      <= '0;
                        col      <= '0;
                    end
                end
                S_ACCUM: begin
                    if (mpe_valid) idx_cnt <= idx_cnt + IDX_W'(1);
                end
                S_FINISH: begin
                    row <= '0;
                    col <= '0;
                end
                S_READ: begin
                    // The last tile address is held rather than wrapped; DONE follows.
                    if (rd_ready && !tile_last) begin
                        if (col_last) begin
                            col <= '0;
                            row <= row + RW'(1);
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ape_sequencer.sv
// Bench for ape_sequencer: table of jobs checked against an event scoreboard,
// plus hand-written reset-state and mid-job reset sequences.
module tb_ape_sequencer;

    localparam int OUT_H       = 8;
    localparam int OUT_W       = 8;
    localparam int OUT_BIN_LEN = 32;
    localparam int IDX_W       = 16;
    localparam int LIMIT       = 70000;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   start;
    logic [IDX_W-1:0]       num_indices;
    logic [OUT_BIN_LEN-1:0] bias_in;
    logic                   mpe_valid;
    logic                   rd_ready;
    logic                   busy;
    logic                   done;
    logic                   ape_w_enable;
    logic [OUT_BIN_LEN-1:0] ape_bias;
    logic                   ape_enable;
    logic                   ape_finish;
    logic                   ape_r_enable;
    logic [2:0]             ape_sram_r;
    logic [2:0]             ape_sram_c;
    logic                   rd_valid;

    int tests = 0;
    int fails = 0;

    ape_sequencer #(
        .OUT_H(OUT_H), .OUT_W(OUT_W), .OUT_BIN_LEN(OUT_BIN_LEN), .IDX_W(IDX_W)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .num_indices(num_indices),
        .bias_in(bias_in), .mpe_valid(mpe_valid), .rd_ready(rd_ready),
        .busy(busy), .done(done), .ape_w_enable(ape_w_enable), .ape_bias(ape_bias),
        .ape_enable(ape_enable), .ape_finish(ape_finish), .ape_r_enable(ape_r_enable),
        .ape_sram_r(ape_sram_r), .ape_sram_c(ape_sram_c), .rd_valid(rd_valid)
    );

    always #5 clock = ~clock;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    typedef enum logic [2:0] {EV_W, EV_E, EV_F, EV_R, EV_D} ev_kind_t;
    typedef struct {
        ev_kind_t          kind;
        logic [31:0]       bias;
        logic [2:0]        r;
        logic [2:0]        c;
    } ev_t;
    ev_t sb[$];

    typedef struct {
        string       name;
        logic [15:0] num;
        logic [31:0] bias;
        logic [15:0] pat;
        int          patlen;
        int          stall_at;
        int          stall_len;
        bit          spam;
        int          exp_fin;
        int          exp_done;
    } vec_t;

    int cur_w, cur_fin, cur_done, cur_acc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input ev_kind_t k, input int cyc);
        ev_t e;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL sb_extra: cycle %0d got %s, expected no more events", cyc, k.name());
        end else begin
            e = sb.pop_front();
            if (e.kind != k) begin
                fails++;
                $display("FAIL sb_order: cycle %0d got %s, expected %s", cyc, k.name(), e.kind.name());
            end else if (k == EV_W && ape_bias !== e.bias) begin
                fails++;
                $display("FAIL sb_bias: cycle %0d got %0h, expected %0h", cyc, ape_bias, e.bias);
            end else if (k == EV_R && (ape_sram_r !== e.r || ape_sram_c !== e.c || ape_r_enable !== 1'b1)) begin
                fails++;
                $display("FAIL sb_read: cycle %0d got (%0d,%0d) ren=%0b, expected (%0d,%0d) ren=1",
                         cyc, ape_sram_r, ape_sram_c, ape_r_enable, e.r, e.c);
            end
        end
    endtask

    task automatic monitor(input int cyc, input logic [31:0] eb);
        chk("busy_in_job", 64'(busy), 64'd1);
        chk("bias_out", 64'(ape_bias), 64'(eb));
        chk("ren_without_rvalid", 64'(ape_r_enable & ~rd_valid), 64'd0);
        if (ape_w_enable) begin expect_ev(EV_W, cyc); cur_w = cyc; end
        if (ape_enable)   expect_ev(EV_E, cyc);
        if (ape_finish)   begin expect_ev(EV_F, cyc); cur_fin = cyc; end
        if (rd_valid && rd_ready) begin expect_ev(EV_R, cyc); cur_acc++; end
        if (rd_valid && !rd_ready) begin
            tests++;
            if (sb.size() == 0 || sb[0].kind != EV_R || sb[0].r !== ape_sram_r ||
                sb[0].c !== ape_sram_c || ape_r_enable !== 1'b1) begin
                fails++;
                $display("FAIL read_hold: cycle %0d address (%0d,%0d) ren=%0b not the pending read",
                         cyc, ape_sram_r, ape_sram_c, ape_r_enable);
            end
        end
        if (done) begin expect_ev(EV_D, cyc); cur_done = cyc; end
    endtask

    task automatic run_job(input vec_t v);
        ev_t         e;
        int          cyc;
        int          pi;
        int          stall_left;
        bit          stalled_once;
        logic [15:0] pat_sh;

        sb.delete();
        e.bias = v.bias; e.r = '0; e.c = '0;
        e.kind = EV_W; sb.push_back(e);
        e.kind = EV_E;
        for (int i = 0; i < int'(v.num); i++) sb.push_back(e);
        e.kind = EV_F; sb.push_back(e);
        e.kind = EV_R;
        for (int r = 0; r < OUT_H; r++)
            for (int c = 0; c < OUT_W; c++) begin
                e.r = 3'(r); e.c = 3'(c); sb.push_back(e);
            end
        e.kind = EV_D; e.r = '0; e.c = '0; sb.push_back(e);

        num_indices = v.num; bias_in = v.bias; start = 1'b1;
        mpe_valid = 1'b1; rd_ready = 1'b1;
        @(posedge clock); #1;
        cyc = 1; pi = 0; stall_left = 0; stalled_once = 1'b0; pat_sh = v.pat;
        cur_w = -1; cur_fin = -1; cur_done = -1; cur_acc = 0;
        while (cur_done < 0 && cyc <= LIMIT) begin
            if (v.spam) begin
                start = 1'b1; num_indices = 16'd9; bias_in = 32'h0000_0099;
            end else begin
                start = 1'b0;
            end
            if (cyc >= 2 && pi < v.patlen) begin
                mpe_valid = pat_sh[0]; pat_sh = pat_sh >> 1; pi++;
            end else begin
                mpe_valid = 1'b1;
            end
            if (rd_valid && !stalled_once && v.stall_len > 0 && cur_acc == v.stall_at) begin
                stall_left = v.stall_len; stalled_once = 1'b1;
            end
            rd_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            @(negedge clock);
            monitor(cyc, v.bias);
            if (cur_done < 0) begin
                @(posedge clock); #1;
                cyc++;
            end
        end
        @(posedge clock); #1;
        start = 1'b0;
        @(negedge clock);
        chk({v.name, "_idle_after_done"}, 64'(busy), 64'd0);
        chk({v.name, "_w_cycle"}, 64'(cur_w), 64'(1));
        chk({v.name, "_fin_cycle"}, 64'(cur_fin), 64'(v.exp_fin));
        chk({v.name, "_done_cycle"}, 64'(cur_done), 64'(v.exp_done));
        chk({v.name, "_events_left"}, 64'(sb.size()), 64'd0);
    endtask

    vec_t vecs[7];

    initial begin
        //          name        num       bias           pat       len stall_at len spam fin    done
        vecs[0] = '{"nominal",  16'd3,    32'h0000_0010, 16'h0000, 0,  0,  0, 1'b0, 5,     70};
        vecs[1] = '{"stall",    16'd4,    32'hDEAD_BEEF, 16'h0059, 7,  0,  0, 1'b0, 9,     74};
        vecs[2] = '{"zero",     16'd0,    32'h0000_0005, 16'h0000, 0,  0,  0, 1'b0, 2,     67};
        vecs[3] = '{"backpr",   16'd1,    32'hA5A5_0001, 16'h0000, 0,  23, 3, 1'b0, 3,     71};
        vecs[4] = '{"spam",     16'd2,    32'h0000_0077, 16'h0000, 0,  0,  0, 1'b1, 4,     69};
        vecs[5] = '{"mixed",    16'd5,    32'h8000_0001, 16'h01AA, 9,  0,  2, 1'b0, 11,    78};
        vecs[6] = '{"maxidx",   16'hFFFF, 32'h0123_4567, 16'h0000, 0,  0,  0, 1'b0, 65537, 65602};

        reset = 1'b1; start = 1'b1; num_indices = 16'd7; bias_in = 32'hFFFF_FFFF;
        mpe_valid = 1'b1; rd_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        @(negedge clock);
        chk("rst_busy",   64'(busy), 64'd0);
        chk("rst_done",   64'(done), 64'd0);
        chk("rst_wen",    64'(ape_w_enable), 64'd0);
        chk("rst_en",     64'(ape_enable), 64'd0);
        chk("rst_fin",    64'(ape_finish), 64'd0);
        chk("rst_ren",    64'(ape_r_enable), 64'd0);
        chk("rst_rvalid", 64'(rd_valid), 64'd0);
        chk("rst_row",    64'(ape_sram_r), 64'd0);
        chk("rst_col",    64'(ape_sram_c), 64'd0);
        chk("rst_bias",   64'(ape_bias), 64'd0);
        reset = 1'b0; start = 1'b0;
        @(posedge clock); #1;
        @(negedge clock);
        chk("idle_busy", 64'(busy), 64'd0);

        // Reset in the ACCUM cycle where the index counter holds 2, with start also high.
        num_indices = 16'd5; bias_in = 32'h0000_1234; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        @(negedge clock);
        chk("mid_wen", 64'(ape_w_enable), 64'd1);
        chk("mid_bias", 64'(ape_bias), 64'h1234);
        @(posedge clock); #1;
        @(negedge clock);
        chk("mid_en0", 64'(ape_enable), 64'd1);
        @(posedge clock); #1;
        @(posedge clock); #1;
        @(negedge clock);
        chk("mid_en2", 64'(ape_enable), 64'd1);
        reset = 1'b1; start = 1'b1; num_indices = 16'd7;
        @(posedge clock); #1;
        @(negedge clock);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_en",   64'(ape_enable), 64'd0);
        chk("mid_rst_strb", 64'({done, ape_w_enable, ape_finish, ape_r_enable, rd_valid}), 64'd0);
        chk("mid_rst_addr", 64'({ape_sram_r, ape_sram_c}), 64'd0);
        chk("mid_rst_bias", 64'(ape_bias), 64'd0);
        reset = 1'b0; start = 1'b0;
        @(posedge clock); #1;

        for (int i = 0; i < 7; i++) run_job(vecs[i]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
